ifu_fetch: RTL and testbench

//  Instruction fetch unit. Supplies pc/instruction to the single-cycle core and takes back

---
 rtl/ifu_fetch.sv | 111 +++++++++++
 tb/tb_ifu_fetch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC and the imem request/response handshake.
// Optional misaligned-target fault when IFU_MISALIGN_CHK_EN is defined.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        commit,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        fetch_err,
    output logic        misalign
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        EXEC,
        ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Handshake outputs depend only on registered state, never on ready.
    assign imem_req_valid = (state == REQ);
    assign imem_addr      = pc;
    assign inst_valid     = (state == EXEC);

`ifdef IFU_MISALIGN_CHK_EN
    logic misalign_q;
    assign misalign = misalign_q;
`else
    logic unused_pc_lsb;
    assign misalign      = 1'b0;
    assign unused_pc_lsb = ^next_pc[1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= '0;
            fetch_err   <= 1'b0;
            cnt         <= '0;
`ifdef IFU_MISALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_req_ready) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    // A response in the timeout cycle still wins.
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            state     <= ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            instruction <= imem_rsp_data;
                            state       <= EXEC;
                        end
                    end else if (cnt == TMAX) begin
                        state     <= ERR;
                        fetch_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (commit) begin
`ifdef IFU_MISALIGN_CHK_EN
                        if (next_pc[1:0] != 2'b00) begin
                            state      <= ERR;
                            fetch_err  <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            pc    <= next_pc;
                            state <= REQ;
                        end
`else
                        pc    <= {next_pc[31:2], 2'b00};
                        state <= REQ;
`endif
                    end
                end
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed fetch/commit/error sequences.
// Expected request addresses and fetched words are queued and checked by a monitor.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] next_pc = '0;
    logic        commit = 1'b0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        fetch_err;
    logic        misalign;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .commit         (commit),
        .pc             (pc),
        .instruction    (instruction),
        .inst_valid     (inst_valid),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .fetch_err      (fetch_err),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] addr_q[$];
    logic [63:0] inst_q[$];
    logic        iv_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted request and every new instruction is scored.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            iv_prev = 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                if (addr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL req_unexpected: got addr %h expected no request", imem_addr);
                end else begin
                    chk("req_addr", imem_addr, addr_q.pop_front());
                end
            end
            if (inst_valid && !iv_prev) begin
                if (inst_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL inst_unexpected: got pc %h inst %h expected none", pc, instruction);
                end else begin
                    e = inst_q.pop_front();
                    chk("inst_pc", pc, e[63:32]);
                    chk("inst_word", instruction, e[31:0]);
                end
            end
            iv_prev = inst_valid;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err = 1'b0;
        commit = 1'b0;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic accept(input logic [31:0] a);
        addr_q.push_back(a);
        imem_req_ready = 1'b1;
        cyc(1);
        imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] p, input logic [31:0] d);
        inst_q.push_back({p, d});
        imem_rsp_valid = 1'b1;
        imem_rsp_data = d;
        cyc(1);
        imem_rsp_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [31:0] np);
        commit = 1'b1;
        next_pc = np;
        cyc(1);
        commit = 1'b0;
        next_pc = 32'hdead_beef;
    endtask

    initial begin
        cyc(2);
        @(negedge clk);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_inst", instruction, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1);

        // Request held while memory stalls
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_valid", 32'(imem_req_valid), 32'd1);
            chk("stall_addr", imem_addr, 32'h8000_0000);
        end
        @(posedge clk);
        #1;
        // Response in the accept cycle must be ignored
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hdead_beef;
        accept(32'h8000_0000);
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("wait_inst_valid", 32'(inst_valid), 32'd0);
        chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
        respond(32'h8000_0000, 32'h0000_0013);

        // Hold in EXEC, then commit
        repeat (3) begin
            @(negedge clk);
            chk("exec_pc", pc, 32'h8000_0000);
            chk("exec_inst", instruction, 32'h0000_0013);
            chk("exec_valid", 32'(inst_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        do_commit(32'h8000_0004);
        @(negedge clk);
        chk("commit_req_valid", 32'(imem_req_valid), 32'd1);
        chk("commit_addr", imem_addr, 32'h8000_0004);
        chk("commit_inst_valid", 32'(inst_valid), 32'd0);
        @(posedge clk);
        #1;
        accept(32'h8000_0004);
        do_commit(32'h9000_0000);
        @(negedge clk);
        chk("wait_commit_pc", pc, 32'h8000_0004);
        respond(32'h8000_0004, 32'h0040_0093);

        // Response exactly at the timeout count wins
        do_commit(32'h8000_0008);
        accept(32'h8000_0008);
        cyc(255);
        @(negedge clk);
        chk("tmo_edge_err", 32'(fetch_err), 32'd0);
        respond(32'h8000_0008, 32'h0081_2083);
        @(negedge clk);
        chk("tmo_rsp_err", 32'(fetch_err), 32'd0);
        chk("tmo_rsp_valid", 32'(inst_valid), 32'd1);

        // No response: timeout fault
        @(posedge clk);
        #1;
        do_commit(32'h8000_000c);
        accept(32'h8000_000c);
        cyc(255);
        @(negedge clk);
        chk("tmo_pre_err", 32'(fetch_err), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("tmo_err", 32'(fetch_err), 32'd1);
        chk("tmo_req_valid", 32'(imem_req_valid), 32'd0);
        chk("tmo_inst_valid", 32'(inst_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h0000_0013;
        imem_req_ready = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("err_sticky", 32'(fetch_err), 32'd1);
        chk("err_req_valid", 32'(imem_req_valid), 32'd0);
        chk("err_inst_valid", 32'(inst_valid), 32'd0);

        // Bus error response
        @(posedge clk);
        #1;
        do_reset();
        cyc(1);
        accept(32'h8000_0000);
        imem_rsp_valid = 1'b1;
        imem_rsp_err = 1'b1;
        cyc(1);
        imem_rsp_valid = 1'b0;
        imem_rsp_err = 1'b0;
        @(negedge clk);
        chk("bus_err", 32'(fetch_err), 32'd1);
        chk("bus_err_valid", 32'(inst_valid), 32'd0);
        chk("bus_err_req", 32'(imem_req_valid), 32'd0);

        // Reset in the middle of WAIT; late response discarded
        @(posedge clk);
        #1;
        do_reset();
        cyc(1);
        accept(32'h8000_0000);
        respond(32'h8000_0000, 32'h0000_0013);
        do_commit(32'h8000_0010);
        accept(32'h8000_0010);
        cyc(2);
        do_reset();
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hbad0_bad0;
        @(negedge clk);
        chk("mid_rst_pc", pc, 32'h8000_0000);
        chk("mid_rst_err", 32'(fetch_err), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("late_rsp_req", 32'(imem_req_valid), 32'd1);
        chk("late_rsp_addr", imem_addr, 32'h8000_0000);
        chk("late_rsp_inst", instruction, 32'h0);
        chk("late_rsp_valid", 32'(inst_valid), 32'd0);
        imem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        accept(32'h8000_0000);
        respond(32'h8000_0000, 32'h0000_0013);

        // Misaligned commit target
        do_commit(32'h8000_0006);
        @(negedge clk);
`ifdef IFU_MISALIGN_CHK_EN
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_err", 32'(fetch_err), 32'd1);
        chk("mis_req", 32'(imem_req_valid), 32'd0);
        chk("mis_pc", pc, 32'h8000_0000);
`else
        chk("mis_flag", 32'(misalign), 32'd0);
        chk("mis_req", 32'(imem_req_valid), 32'd1);
        chk("mis_addr", imem_addr, 32'h8000_0004);
        @(posedge clk);
        #1;
        accept(32'h8000_0004);
        respond(32'h8000_0004, 32'h0000_0013);
        @(negedge clk);
        chk("mis_err", 32'(fetch_err), 32'd0);
`endif

        cyc(2);
        chk("sb_addr_left", 32'(addr_q.size()), 32'd0);
        chk("sb_inst_left", 32'(inst_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
